// File: rtl/seg_scan_capture.sv
// Seven-segment bus snooper: recovers the hex nibble shown on each of four digits.
// Optional per-digit staleness timeout enabled by defining SEG_TIMEOUT_EN.
module seg_scan_capture #(
    parameter int STABLE_CNT = 4,
    parameter int TIMEOUT    = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  seg,
    input  logic [3:0]  dig_en,
    output logic [15:0] val,
    output logic [3:0]  digit_valid,
    output logic [3:0]  err,
    output logic        frame_done
);

    typedef enum logic [1:0] {
        IDLE,
        TRACK,
        HOLD
    } state_t;

    localparam logic [3:0] LAST = 4'(STABLE_CNT - 1);

    if (STABLE_CNT < 2 || STABLE_CNT > 15 || TIMEOUT < 2) begin : g_bad_param
        $error("seg_scan_capture: parameter out of range");
    end

    logic [6:0] seg_q;
    logic [3:0] dig_q;
    state_t     state;
    logic [1:0] cand_idx;
    logic [6:0] cand_pat;
    logic [3:0] cnt;
    logic [3:0] mask;

    logic       usable;
    logic [1:0] idx;
    logic       same;
    logic       commit;
    logic [4:0] dec;
    logic [3:0] hit;

`ifdef SEG_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo [4];
`endif

    function automatic logic [4:0] decode(input logic [6:0] p);
        logic [4:0] r;
        r = 5'h00;
        case (p)
            7'h01:   r = 5'h10;
            7'h4F:   r = 5'h11;
            7'h12:   r = 5'h12;
            7'h06:   r = 5'h13;
            7'h4C:   r = 5'h14;
            7'h24:   r = 5'h15;
            7'h20:   r = 5'h16;
            7'h0F:   r = 5'h17;
            7'h00:   r = 5'h18;
            7'h04:   r = 5'h19;
            7'h08:   r = 5'h1A;
            7'h60:   r = 5'h1B;
            7'h31:   r = 5'h1C;
            7'h42:   r = 5'h1D;
            7'h30:   r = 5'h1E;
            7'h38:   r = 5'h1F;
            default: r = 5'h00;
        endcase
        return r;
    endfunction

    // exactly one active-low enable makes the sample usable
    always_comb begin
        usable = 1'b1;
        idx    = 2'd0;
        case (dig_q)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: usable = 1'b0;
        endcase
    end

    always_comb begin
        same   = usable && (idx == cand_idx) && (seg_q == cand_pat);
        commit = (state == TRACK) && same && (cnt == LAST);
        dec    = decode(cand_pat);
        hit    = commit ? (4'b0001 << cand_idx) : 4'b0000;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q <= 7'h7F;
            dig_q <= 4'hF;
        end else begin
            seg_q <= seg;
            dig_q <= dig_en;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cand_idx    <= 2'd0;
            cand_pat    <= 7'h7F;
            cnt         <= 4'd0;
            mask        <= 4'd0;
            val         <= 16'h0000;
            digit_valid <= 4'b0000;
            err         <= 4'b0000;
            frame_done  <= 1'b0;
`ifdef SEG_TIMEOUT_EN
            for (int k = 0; k < 4; k++) tmo[k] <= '0;
`endif
        end else begin
            if (!usable) begin
                state <= IDLE;
                cnt   <= 4'd0;
            end else if (state == IDLE || !same) begin
                state    <= TRACK;
                cand_idx <= idx;
                cand_pat <= seg_q;
                cnt      <= 4'd1;
            end else if (state == TRACK) begin
                if (cnt != 4'hF) cnt <= cnt + 4'd1;
                if (commit) state <= HOLD;
            end

            if (mask == 4'hF) begin
                frame_done <= 1'b1;
                mask       <= hit;
            end else begin
                frame_done <= 1'b0;
                mask       <= mask | hit;
            end

`ifdef SEG_TIMEOUT_EN
            // staleness is evaluated first so a same-cycle commit overrides it
            for (int k = 0; k < 4; k++) begin
                if (hit[k]) begin
                    tmo[k] <= '0;
                end else if (tmo[k] != TW'(TIMEOUT)) begin
                    tmo[k] <= tmo[k] + 1'b1;
                    if (tmo[k] == TW'(TIMEOUT - 1)) digit_valid[k] <= 1'b0;
                end
            end
`endif

            if (commit) begin
                if (dec[4]) begin
                    val[cand_idx*4 +: 4]  <= dec[3:0];
                    digit_valid[cand_idx] <= 1'b1;
                    err[cand_idx]         <= 1'b0;
                end else begin
                    digit_valid[cand_idx] <= 1'b0;
                    err[cand_idx]         <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_capture.sv
// Self-checking bench for seg_scan_capture (STABLE_CNT=4).
module tb_seg_scan_capture;

`ifdef SEG_TIMEOUT_EN
    localparam int TMO = 64;
`else
    localparam int TMO = 4096;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  seg;
    logic [3:0]  dig_en;
    logic [15:0] val;
    logic [3:0]  digit_valid;
    logic [3:0]  err;
    logic        frame_done;

    always #5 clk = ~clk;

    seg_scan_capture #(
        .STABLE_CNT(4),
        .TIMEOUT   (TMO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .seg        (seg),
        .dig_en     (dig_en),
        .val        (val),
        .digit_valid(digit_valid),
        .err        (err),
        .frame_done (frame_done)
    );

    typedef struct {
        logic [3:0]  d;
        logic [6:0]  s;
        int          n;
        logic [15:0] v;
        logic [3:0]  dv;
        logic [3:0]  er;
        bit          fd;
    } vec_t;

    vec_t tab [8];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   fd_q[$];
    int   fd_exp;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // scoreboard side: every frame_done pulse must match a queued cycle
    always @(negedge clk) begin
        if (rst_n === 1'b1 && frame_done === 1'b1) begin
            total++;
            if (fd_q.size() == 0) begin
                bad++;
                $display("FAIL frame_done: unexpected pulse at cycle %0d", cyc);
            end else begin
                fd_exp = fd_q.pop_front();
                if (fd_exp != cyc) begin
                    bad++;
                    $display("FAIL frame_done: pulse at cycle %0d want %0d",
                             cyc, fd_exp);
                end
            end
        end
    end

    task automatic drive(input logic [3:0] d, input logic [6:0] s,
                         input int n);
        dig_en = d;
        seg    = s;
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_vec(input int i);
        // candidate seen 2 edges in, commit at edge 5, pulse one edge later
        if (tab[i].fd) fd_q.push_back(cyc + 6);
        drive(tab[i].d, tab[i].s, tab[i].n);
        chk($sformatf("v%0d val", i), 32'(val), 32'(tab[i].v));
        chk($sformatf("v%0d valid", i), 32'(digit_valid), 32'(tab[i].dv));
        chk($sformatf("v%0d err", i), 32'(err), 32'(tab[i].er));
    endtask

    initial begin
        tab[0] = '{4'b1110, 7'h06, 6,  16'h0003, 4'b0001, 4'b0000, 1'b0};
        tab[1] = '{4'b1110, 7'h12, 8,  16'h00B2, 4'b0011, 4'b0000, 1'b0};
        tab[2] = '{4'b1101, 7'h08, 8,  16'h00A2, 4'b0011, 4'b0000, 1'b0};
        tab[3] = '{4'b1011, 7'h24, 8,  16'h05A2, 4'b0111, 4'b0000, 1'b0};
        tab[4] = '{4'b0111, 7'h38, 8,  16'hF5A2, 4'b1111, 4'b0000, 1'b1};
        tab[5] = '{4'b1011, 7'h7F, 5,  16'hF5A2, 4'b1011, 4'b0100, 1'b0};
        tab[6] = '{4'b1011, 7'h01, 5,  16'hF0A2, 4'b1111, 4'b0000, 1'b0};
        tab[7] = '{4'b1100, 7'h12, 10, 16'hF0A2, 4'b1111, 4'b0000, 1'b0};

        rst_n  = 1'b0;
        dig_en = 4'hF;
        seg    = 7'h7F;
        repeat (2) @(negedge clk);
        chk("reset val", 32'(val), 32'h0);
        chk("reset valid", 32'(digit_valid), 32'h0);
        chk("reset err", 32'(err), 32'h0);
        chk("reset frame_done", 32'(frame_done), 32'h0);
        rst_n = 1'b1;

        run_vec(0);

        // glitch: A held too briefly must never reach digit 1
        drive(4'b1101, 7'h08, 3);
        drive(4'b1101, 7'h60, 1);
        chk("glitch transient", 32'(val[7:4]), 32'h0);
        drive(4'b1101, 7'h60, 4);
        chk("glitch val", 32'(val), 32'h00B3);
        chk("glitch valid", 32'(digit_valid), 32'h3);
        chk("glitch err", 32'(err), 32'h0);

        for (int i = 1; i < 8; i++) run_vec(i);

        // asynchronous reset in the middle of tracking
        drive(4'b1101, 7'h4F, 3);
        #2 rst_n = 1'b0;
        #1;
        chk("async val", 32'(val), 32'h0);
        chk("async valid", 32'(digit_valid), 32'h0);
        chk("async err", 32'(err), 32'h0);
        chk("async frame_done", 32'(frame_done), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(4'b1101, 7'h4F, 3);
        chk("post-reset no commit", 32'(digit_valid), 32'h0);
        drive(4'b1101, 7'h4F, 2);
        chk("post-reset val", 32'(val), 32'h0010);
        chk("post-reset valid", 32'(digit_valid), 32'h2);

        // staleness boundary on digit 3
        drive(4'b0111, 7'h38, 5);
        chk("d3 commit val", 32'(val), 32'hF010);
        chk("d3 commit valid", 32'(digit_valid), 32'hA);
        drive(4'b1111, 7'h7F, 63);
        chk("blank63 valid3", 32'(digit_valid[3]), 32'h1);
        drive(4'b1111, 7'h7F, 1);
`ifdef SEG_TIMEOUT_EN
        chk("blank64 valid3", 32'(digit_valid[3]), 32'h0);
`else
        chk("blank64 valid3", 32'(digit_valid[3]), 32'h1);
`endif
        chk("blank64 val", 32'(val), 32'hF010);
        chk("blank64 err", 32'(err), 32'h0);

        chk("frame queue drained", 32'(fd_q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
